// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file access scheduler.
package regfile_pkg;

  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 5;
  localparam int NREGS      = 32;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } host_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WRITE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } host_state_t;

  // Counter width able to hold the value STARVE_MAX itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter. The grant is combinational; the priority
// pointer is registered and moves away from whichever side was granted.
// i_hold masks all requests for the current cycle.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_hold,
  output logic [1:0] o_gnt
);

  logic       r_prio1;   // 1: requester 1 wins a tie, 0: requester 0 wins
  logic [1:0] w_req;

  // Grant selection: single requester wins outright, ties follow the pointer.
  always_comb begin
    w_req = i_hold ? 2'b00 : i_req;
    o_gnt = 2'b00;
    if (w_req == 2'b11) begin
      o_gnt = r_prio1 ? 2'b10 : 2'b01;
    end else begin
      o_gnt = w_req;
    end
  end

  // Priority pointer: after a grant the other side gets the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio1 <= 1'b0;
    end else if (o_gnt[0]) begin
      r_prio1 <= 1'b1;
    end else if (o_gnt[1]) begin
      r_prio1 <= 1'b0;
    end else begin
      r_prio1 <= r_prio1;
    end
  end

endmodule

// File: rtl/regfile_port_sched.sv
// Access scheduler for the 32x64 register file: round-robin sharing of the
// pipeline write port between two writeback requesters, plus a host FSM
// driving the host port for single writes, single reads and full dumps.
module regfile_port_sched
  import regfile_pkg::*;
#(
  parameter int P_DATA_W     = DATA_W,
  parameter int P_ADDR_W     = ADDR_W,
  parameter int P_NREGS      = NREGS,
  parameter int P_STARVE_MAX = STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb0_valid,
  output logic                wb0_ready,
  input  logic [P_ADDR_W-1:0] wb0_addr,
  input  logic [P_DATA_W-1:0] wb0_data,
  input  logic                wb1_valid,
  output logic                wb1_ready,
  input  logic [P_ADDR_W-1:0] wb1_addr,
  input  logic [P_DATA_W-1:0] wb1_data,
  input  logic                host_cmd_valid,
  output logic                host_cmd_ready,
  input  logic [1:0]          host_cmd_op,
  input  logic [P_ADDR_W-1:0] host_cmd_addr,
  input  logic [P_DATA_W-1:0] host_cmd_data,
  output logic                host_rsp_valid,
  input  logic                host_rsp_ready,
  output logic [P_ADDR_W-1:0] host_rsp_addr,
  output logic [P_DATA_W-1:0] host_rsp_data,
  output logic                host_rsp_last,
  output logic                rf_wena,
  output logic [P_ADDR_W-1:0] rf_waddr,
  output logic [P_DATA_W-1:0] rf_wdata,
  output logic                rf_swena,
  output logic [P_ADDR_W-1:0] rf_swaddr,
  output logic [P_DATA_W-1:0] rf_swdata,
  input  logic [P_DATA_W-1:0] rf_dff
);

  localparam int CNT_W = cnt_width(P_STARVE_MAX);
  localparam logic [P_ADDR_W-1:0] LAST_ADDR = P_ADDR_W'(P_NREGS - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(P_STARVE_MAX);

  host_state_t         r_state;
  host_state_t         w_state_nxt;
  logic [P_ADDR_W-1:0] r_addr;
  logic [P_DATA_W-1:0] r_data;
  logic [P_DATA_W-1:0] r_rsp_data;
  logic                r_dump;
  logic [CNT_W-1:0]    r_blk_cnt;

  logic [1:0]          w_gnt;
  logic                w_wb_xfer;
  logic [P_ADDR_W-1:0] w_waddr;
  logic                w_starve;
  logic                w_conflict;
  logic                w_cmd_acc;
  logic                w_rsp_hs;
  logic                w_last;
  logic                w_swena;

  // While a starved host write is pending, both writebacks are held off.
  assign w_starve = (r_state == ST_WRITE) && (r_blk_cnt == CNT_MAX);

  rr_arb2 u_wb_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  ({wb1_valid, wb0_valid}),
    .i_hold (w_starve),
    .o_gnt  (w_gnt)
  );

  // Writeback port mux: granted requester's fields, zero when idle.
  always_comb begin
    w_wb_xfer = |w_gnt;
    w_waddr   = w_gnt[1] ? wb1_addr : wb0_addr;
    wb0_ready = w_gnt[0];
    wb1_ready = w_gnt[1];
    rf_wena   = w_wb_xfer;
    if (w_wb_xfer) begin
      rf_waddr = w_waddr;
      rf_wdata = w_gnt[1] ? wb1_data : wb0_data;
    end else begin
      rf_waddr = {P_ADDR_W{1'b0}};
      rf_wdata = {P_DATA_W{1'b0}};
    end
  end

  // Host FSM next state and host-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_swena     = 1'b0;
    w_cmd_acc   = (r_state == ST_IDLE) && host_cmd_valid;
    w_rsp_hs    = (r_state == ST_RESP) && host_rsp_ready;
    w_last      = (r_state == ST_RESP) && (!r_dump || (r_addr == LAST_ADDR));
    w_conflict  = w_wb_xfer && (w_waddr == r_addr);
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          case (host_op_t'(host_cmd_op))
            OP_WRITE: w_state_nxt = ST_WRITE;
            OP_READ:  w_state_nxt = ST_CAPTURE;
            OP_DUMP:  w_state_nxt = ST_CAPTURE;
            default:  w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!w_conflict) begin
          w_swena     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = (r_dump && !w_last) ? ST_CAPTURE : ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    host_cmd_ready = (r_state == ST_IDLE);
    host_rsp_valid = (r_state == ST_RESP);
    host_rsp_last  = w_last;
    host_rsp_addr  = (r_state == ST_RESP) ? r_addr : {P_ADDR_W{1'b0}};
    host_rsp_data  = (r_state == ST_RESP) ? r_rsp_data : {P_DATA_W{1'b0}};
    rf_swena       = w_swena;
    rf_swaddr      = ((r_state == ST_WRITE) || (r_state == ST_CAPTURE)) ? r_addr : {P_ADDR_W{1'b0}};
    rf_swdata      = (r_state == ST_WRITE) ? r_data : {P_DATA_W{1'b0}};
  end

  // Host FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Host datapath: latched command, dump address walk, blocked counter, read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= {P_ADDR_W{1'b0}};
      r_data     <= {P_DATA_W{1'b0}};
      r_rsp_data <= {P_DATA_W{1'b0}};
      r_dump     <= 1'b0;
      r_blk_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            r_addr    <= (host_op_t'(host_cmd_op) == OP_DUMP) ? {P_ADDR_W{1'b0}} : host_cmd_addr;
            r_data    <= host_cmd_data;
            r_dump    <= (host_op_t'(host_cmd_op) == OP_DUMP);
            r_blk_cnt <= {CNT_W{1'b0}};
          end
        end
        ST_WRITE: begin
          // A starved cycle never conflicts, so the counter stops at its max.
          if (w_swena) begin
            r_blk_cnt <= {CNT_W{1'b0}};
          end else begin
            r_blk_cnt <= r_blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_CAPTURE: begin
          r_rsp_data <= rf_dff;
        end
        ST_RESP: begin
          if (w_rsp_hs && r_dump && !w_last) begin
            r_addr <= r_addr + {{(P_ADDR_W-1){1'b0}}, 1'b1};
          end else if (w_rsp_hs && w_last) begin
            r_dump <= 1'b0;
          end
        end
        default: begin
          r_dump <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Scoreboard bench for regfile_port_sched with a behavioural register file.
module tb_regfile_port_sched;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [ADDR_W-1:0] wb0_addr, wb1_addr;
  logic [DATA_W-1:0] wb0_data, wb1_data;
  logic              host_cmd_valid, host_cmd_ready;
  logic [1:0]        host_cmd_op;
  logic [ADDR_W-1:0] host_cmd_addr;
  logic [DATA_W-1:0] host_cmd_data;
  logic              host_rsp_valid, host_rsp_ready, host_rsp_last;
  logic [ADDR_W-1:0] host_rsp_addr;
  logic [DATA_W-1:0] host_rsp_data;
  logic              rf_wena, rf_swena;
  logic [ADDR_W-1:0] rf_waddr, rf_swaddr;
  logic [DATA_W-1:0] rf_wdata, rf_swdata, rf_dff;

  logic [DATA_W-1:0] mem [NREGS];

  logic [ADDR_W+DATA_W-1:0] wb_q[$];
  logic [ADDR_W+DATA_W-1:0] sw_q[$];
  logic [ADDR_W+DATA_W:0]   rsp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  regfile_port_sched dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready), .host_cmd_op(host_cmd_op),
    .host_cmd_addr(host_cmd_addr), .host_cmd_data(host_cmd_data),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready), .host_rsp_addr(host_rsp_addr),
    .host_rsp_data(host_rsp_data), .host_rsp_last(host_rsp_last),
    .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_swena(rf_swena), .rf_swaddr(rf_swaddr), .rf_swdata(rf_swdata), .rf_dff(rf_dff)
  );

  // Register file model: host port reads combinationally, both ports commit on the edge.
  assign rf_dff = mem[rf_swaddr];
  initial begin
    for (int i = 0; i < NREGS; i++) mem[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    forever begin
      @(posedge clk);
      if (rf_wena)  mem[rf_waddr]  <= rf_wdata;
      if (rf_swena) mem[rf_swaddr] <= rf_swdata;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Hand-computed final contents after the writes issued before the dump.
  function automatic logic [DATA_W-1:0] exp_val(input int i);
    case (i)
      2:       return 64'h77;
      3:       return 64'hA;
      4:       return 64'hB;
      7:       return 64'h55;
      default: return 64'hC0DE_0000_0000_0000 + 64'(i);
    endcase
  endfunction

  // Writeback-port monitor.
  initial forever begin
    @(negedge clk);
    if (rf_wena) begin
      if (wb_q.size() == 0) check("wb_unexpected", 128'(rf_waddr), 128'hFFFF);
      else check("wb_port", 128'({rf_waddr, rf_wdata}), 128'(wb_q.pop_front()));
    end
  end

  // Host-write-port monitor plus port collision check.
  initial forever begin
    @(negedge clk);
    if (rf_swena) begin
      if (sw_q.size() == 0) check("sw_unexpected", 128'(rf_swaddr), 128'hFFFF);
      else check("sw_port", 128'({rf_swaddr, rf_swdata}), 128'(sw_q.pop_front()));
      if (rf_wena) check("port_collision", 128'(rf_waddr == rf_swaddr), 128'd0);
    end
  end

  // Response monitor with hold-stability tracking.
  initial begin
    logic              hold_v;
    logic [ADDR_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_d;
    hold_v = 1'b0; hold_a = '0; hold_d = '0;
    forever begin
      @(negedge clk);
      if (hold_v && host_rsp_valid)
        check("rsp_stable", 128'({host_rsp_addr, host_rsp_data}), 128'({hold_a, hold_d}));
      if (host_rsp_valid && host_rsp_ready) begin
        hs_cnt++;
        if (rsp_q.size() == 0) check("rsp_unexpected", 128'(host_rsp_addr), 128'hFFFF);
        else check("rsp_beat", 128'({host_rsp_addr, host_rsp_data, host_rsp_last}), 128'(rsp_q.pop_front()));
      end
      hold_v = host_rsp_valid && !host_rsp_ready;
      hold_a = host_rsp_addr;
      hold_d = host_rsp_data;
    end
  end

  // Issue one host command; returns #1 after the accepting edge.
  task automatic host_send(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int k;
    @(posedge clk); #1;
    host_cmd_valid = 1'b1; host_cmd_op = op; host_cmd_addr = a; host_cmd_data = d;
    k = 0;
    @(negedge clk);
    while (!host_cmd_ready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) check("cmd_accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    host_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int k;
    k = 0;
    while (rsp_q.size() != 0 && k < max) begin @(negedge clk); k++; end
    check("rsp_drain", 128'(rsp_q.size()), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    host_cmd_valid = 1'b0; host_cmd_op = 2'b00; host_cmd_addr = '0; host_cmd_data = '0;
    host_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 128'({host_cmd_ready, host_rsp_valid, rf_wena, rf_swena, wb0_ready, wb1_ready, host_rsp_last}), 128'(7'b1000000));
    check("reset_addr", 128'({rf_waddr, rf_swaddr, host_rsp_addr}), 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Both writebacks valid for four cycles: grants alternate starting with wb0.
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 64'hA;
    wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 64'hB;
    for (int k = 0; k < 4; k++) wb_q.push_back((k % 2 == 0) ? {5'd3, 64'hA} : {5'd4, 64'hB});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_grant", 128'({wb1_ready, wb0_ready}), (k % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      @(posedge clk); #1;
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;

    // Host write to 7 then read back.
    sw_q.push_back({5'd7, 64'h55});
    host_send(2'b00, 5'd7, 64'h55);
    @(negedge clk);
    check("hwrite_latency", 128'(rf_swena), 128'd1);
    rsp_q.push_back({5'd7, 64'h55, 1'b1});
    host_send(2'b01, 5'd7, 64'h0);
    @(negedge clk);
    check("read_lat_c1", 128'(host_rsp_valid), 128'd0);
    @(negedge clk);
    check("read_lat_c2", 128'(host_rsp_valid), 128'd1);
    wait_drain(20);

    // Host write to 2 while wb0 hammers addr 2: four blocked cycles, then forced through.
    @(posedge clk); #1;
    wb0_valid = 1'b1; wb0_addr = 5'd2; wb0_data = 64'h99;
    host_cmd_valid = 1'b1; host_cmd_op = 2'b00; host_cmd_addr = 5'd2; host_cmd_data = 64'h77;
    for (int k = 0; k < 5; k++) wb_q.push_back({5'd2, 64'h99});
    sw_q.push_back({5'd2, 64'h77});
    @(posedge clk); #1 host_cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("starve_blocked", 128'(rf_swena), 128'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("starve_force", 128'({wb0_ready, rf_swena}), 128'(2'b01));
    @(posedge clk); #1 wb0_valid = 1'b0;
    rsp_q.push_back({5'd2, 64'h77, 1'b1});
    host_send(2'b01, 5'd2, 64'h0);
    wait_drain(20);

    // Reserved op: accepted, nothing happens.
    base = hs_cnt;
    host_send(2'b11, 5'd5, 64'hDEAD);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rsvd_idle", 128'({host_cmd_ready, host_rsp_valid, rf_swena}), 128'(3'b100));
    end

    // Full dump with rsp_ready toggling every cycle.
    for (int i = 0; i < NREGS; i++) rsp_q.push_back({5'(i), exp_val(i), (i == NREGS - 1)});
    host_send(2'b10, 5'd0, 64'h0);
    for (int k = 0; k < 300 && rsp_q.size() != 0; k++) begin
      @(posedge clk); #1 host_rsp_ready = ~host_rsp_ready;
    end
    host_rsp_ready = 1'b1;
    wait_drain(4);
    check("dump_beats", 128'(hs_cnt - base), 128'd32);
    repeat (3) @(negedge clk);
    check("dump_done_idle", 128'(host_cmd_ready), 128'd1);

    // Reset after the 10th dump beat aborts the dump.
    for (int i = 0; i < 10; i++) rsp_q.push_back({5'(i), exp_val(i), 1'b0});
    base = hs_cnt;
    host_send(2'b10, 5'd0, 64'h0);
    for (int k = 0; k < 200 && hs_cnt < base + 10; k++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_state", 128'({host_rsp_valid, host_cmd_ready}), 128'(2'b01));
    repeat (4) @(negedge clk);
    check("abort_no_resume", 128'(hs_cnt - base), 128'd10);
    base = hs_cnt;
    rsp_q.push_back({5'd0, exp_val(0), 1'b1});
    host_send(2'b01, 5'd0, 64'h0);
    wait_drain(20);
    repeat (6) @(negedge clk);
    check("single_beat", 128'(hs_cnt - base), 128'd1);
    check("wb_q_empty", 128'(wb_q.size()), 128'd0);
    check("sw_q_empty", 128'(sw_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
